serial_magnitude_comparator: RTL
================================

# serial_magnitude_comparator

Bit-serial magnitude comparator that scans operands LSB-first, one bit per clock. It is the sequential, reverse-scan counterpart of the team's parallel MSB-first cascaded comparator. It accepts the same cascade inputs (greater and equal flags from a more-significant slice) and produces the same greater and equal outputs. It trades area for latency in wide-operand paths where a full parallel chain is too large.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..64.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- x  input  WIDTH  operand X; sampled with start.
- y  input  WIDTH  operand Y; sampled with start.
- in_gt  input  1  cascade greater flag from the more-significant slice; sampled with start.
- in_eq  input  1  cascade equal flag from the more-significant slice; sampled with start.
- busy  output  1  high while scanning.
- done  output  1  one-cycle pulse when the result is updated.
- o_gt  output  1  registered result, X > Y (cascade-qualified).
- o_eq  output  1  registered result, X == Y (cascade-qualified).

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE or DONE with start=1:
  - Latch x, y, in_gt, in_eq into shift and flag registers.
  - Clear the running accumulator to gt_acc=0, eq_acc=1.
  - Load the bit counter with WIDTH-1.
  - Go to SCAN.
- DONE with start=0: go to IDLE. o_gt and o_eq hold.
- SCAN, each cycle on the current LSB pair (xb, yb):
  - If xb != yb: gt_acc=xb, eq_acc=0.
  - Else: accumulator unchanged.
  - Shift both operand registers right by one.
  - A later (more significant) differing bit overrides an earlier one.
- SCAN with counter==0: process the final bit, then commit and go to DONE.
- Commit rule:
  - If latched in_eq=0: o_gt=latched in_gt, o_eq=0.
  - Else: o_gt=final gt_acc, o_eq=final eq_acc.
  - in_gt is ignored whenever in_eq=1.
- start while in SCAN is ignored. No queuing; no error flag.
- Fixed latency. There is no early exit on a difference.
- Counter width is $clog2(WIDTH). The counter decrements and never wraps below 0 within a scan.

## Timing
- Reset values:
  - State IDLE.
  - busy=0, done=0, o_gt=0, o_eq=0.
  - Counter 0.
  - Shift and flag registers 0.
- Reset takes effect immediately (asynchronous) and is released synchronously to clk by the system.
- Reset asserted mid-SCAN:
  - Scan is abandoned and no done pulse is issued.
  - After release, the next start runs a full-length scan.
- Start sampled at edge E:
  - busy=1 from after E through after E+WIDTH-1, i.e. WIDTH cycles.
  - Bits 0..WIDTH-1 are processed at edges E+1..E+WIDTH.
  - o_gt, o_eq and done update at edge E+WIDTH. done is high exactly one cycle.
- busy and done are never high together.
- Back-to-back operation: start=1 during the done cycle is accepted. busy rises at the next edge. This gives one result per WIDTH+1 cycles with no idle gap.
- Operand changes after the sampling edge have no effect on the result in flight.

## Structure
- Shared package serial_cmp_pkg holds:
  - State enum type cmp_state_t {IDLE, SCAN, DONE}.
  - Reset-value localparams for the outputs.
- Counter width is derived locally from WIDTH.
- One combinational sub-module, lsb_bit_update:
  - Inputs: xb, yb, gt_acc, eq_acc.
  - Outputs: next gt_acc, next eq_acc.
  - Applies the override rule above.
- The top module owns the FSM, counter, shift registers, cascade qualification and output registers.

## Test plan
All scenarios use WIDTH=8.

- x=0xA5, y=0xA5, in_gt=0, in_eq=1, start at edge 0:
  - busy high for 8 cycles.
  - done at edge 8 with o_gt=0, o_eq=1.
- x=0x80, y=0x7F, in_eq=1: o_gt=1, o_eq=0. The MSB overrides seven lower differing bits.
- x=0x01, y=0x02, in_eq=1: o_gt=0, o_eq=0.
- x=0x00, y=0xFF, in_gt=1, in_eq=0: o_gt=1, o_eq=0. Cascade dominates the operands.
- Busy and reset handling:
  - Start pulses at edges 3 and 5 during SCAN are ignored, and a single done occurs at edge 8.
  - A separate run with rst_n low at cycle 4: outputs 0, IDLE, no done.
  - A new start after reset gives done 8 edges later with the correct result.
- Back-to-back starts:
  - start held high across the done cycle, with x=0x10,y=0x0F then x=0x0F,y=0x10.
  - Done pulses at edges 8 and 17, giving results (gt=1,eq=0) then (gt=0,eq=0).

Source files
------------

// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared types and reset values for the bit-serial magnitude comparator.
// The FSM state type and the output reset levels live here so the bench and RTL agree.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  localparam logic RST_O_GT = 1'b0;
  localparam logic RST_O_EQ = 1'b0;

endpackage

// File: rtl/serial_magnitude_comparator_if.sv
// Request/result bundle of the bit-serial comparator.
// The master drives operands and start; the slave returns status and the result.
interface serial_magnitude_comparator_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             in_gt;
  logic             in_eq;
  logic             busy;
  logic             done;
  logic             o_gt;
  logic             o_eq;

  modport master (
    output start, x, y, in_gt, in_eq,
    input  busy, done, o_gt, o_eq
  );

  modport slave (
    input  start, x, y, in_gt, in_eq,
    output busy, done, o_gt, o_eq
  );

endinterface

// File: rtl/serial_magnitude_comparator_lsb_bit_update.sv
// One step of the LSB-first comparison: a differing bit pair overrides whatever
// the less significant bits decided, an equal pair leaves the accumulator alone.
module lsb_bit_update (
  input  logic xb,
  input  logic yb,
  input  logic gt_acc,
  input  logic eq_acc,
  output logic gt_next,
  output logic eq_next
);

  logic differ;

  assign differ  = xb ^ yb;
  assign gt_next = differ ? xb   : gt_acc;
  assign eq_next = differ ? 1'b0 : eq_acc;

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial magnitude comparator: scans X and Y LSB-first over WIDTH cycles and
// qualifies the result with the cascade flags of the more significant slice.
module serial_magnitude_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  serial_magnitude_comparator_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  cmp_state_t       state;
  cmp_state_t       state_next;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] sx;
  logic [WIDTH-1:0] sy;
  logic             f_gt;
  logic             f_eq;
  logic             gt_acc;
  logic             eq_acc;
  logic             gt_nxt;
  logic             eq_nxt;
  logic             o_gt_r;
  logic             o_eq_r;
  logic             load;
  logic             last;

  lsb_bit_update u_bit (
    .xb      (sx[0]),
    .yb      (sy[0]),
    .gt_acc  (gt_acc),
    .eq_acc  (eq_acc),
    .gt_next (gt_nxt),
    .eq_next (eq_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (count == '0) state_next = DONE;
      end
      DONE: begin
        load       = bus.start;
        state_next = bus.start ? SCAN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign last = (state == SCAN) && (count == '0);

  // Operand shifters, accumulator and counter; the result commits on the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx     <= '0;
      sy     <= '0;
      f_gt   <= 1'b0;
      f_eq   <= 1'b0;
      gt_acc <= 1'b0;
      eq_acc <= 1'b0;
      count  <= '0;
      o_gt_r <= RST_O_GT;
      o_eq_r <= RST_O_EQ;
    end else if (load) begin
      sx     <= bus.x;
      sy     <= bus.y;
      f_gt   <= bus.in_gt;
      f_eq   <= bus.in_eq;
      gt_acc <= 1'b0;
      eq_acc <= 1'b1;
      count  <= CNT_W'(WIDTH - 1);
    end else if (state == SCAN) begin
      sx     <= sx >> 1;
      sy     <= sy >> 1;
      gt_acc <= gt_nxt;
      eq_acc <= eq_nxt;
      if (count != '0) count <= count - CNT_W'(1);
      if (last) begin
        // A non-equal upstream slice decides the result regardless of the operands.
        o_gt_r <= f_eq ? gt_nxt : f_gt;
        o_eq_r <= f_eq & eq_nxt;
      end
    end
  end

  assign bus.busy = (state == SCAN);
  assign bus.done = (state == DONE);
  assign bus.o_gt = o_gt_r;
  assign bus.o_eq = o_eq_r;

endmodule
